// File: rtl/adder_chunk_scheduler.sv
// Two-requester, round-robin scheduler that streams WIDTH-bit additions through a
// shared 8-bit carry-less adder, one byte per cycle, rebuilding the carry chain itself.
module adder_chunk_scheduler #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic [7:0]       dp_a,
    output logic [7:0]       dp_b,
    input  logic [7:0]       dp_s,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / 8;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_sum;
    logic [IDXW-1:0]   r_idx;
    logic              r_carry;
    logic              r_cout;
    logic              r_id;
    logic              r_rsp_id;
    logic              r_last_grant;

    logic              w_gnt0;
    logic              w_gnt1;
    logic [IDXW+2:0]   w_shift;
    logic [7:0]        w_slice_a;
    logic [7:0]        w_slice_b;
    logic [8:0]        w_t;
    logic              w_carry_next;
    logic [WIDTH-1:0]  w_acc_next;

    // Round-robin: on contention the requester that did not win last time goes first.
    assign w_gnt0 = (r_state == S_IDLE) && req0_valid && (!req1_valid || r_last_grant);
    assign w_gnt1 = (r_state == S_IDLE) && req1_valid && (!req0_valid || !r_last_grant);

    assign w_shift   = {r_idx, 3'b000};
    assign w_slice_a = 8'(r_a >> w_shift);
    assign w_slice_b = 8'(r_b >> w_shift);

    // The external adder has no carry in/out: add the incoming carry here and
    // recover the byte carry-out from the slice MSBs and the adder's bit 7.
    assign w_t          = {1'b0, dp_s} + {8'b0, r_carry};
    assign w_carry_next = (w_slice_a[7] & w_slice_b[7])
                        | ((w_slice_a[7] ^ w_slice_b[7]) & ~dp_s[7])
                        | w_t[8];

    always_comb begin
        w_acc_next = (r_acc & ~(WIDTH'(8'hFF) << w_shift))
                   | (WIDTH'(w_t[7:0]) << w_shift);
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign dp_a       = (r_state == S_RUN) ? w_slice_a : 8'h00;
    assign dp_b       = (r_state == S_RUN) ? w_slice_b : 8'h00;
    assign rsp_valid  = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE);
    assign rsp_id     = r_rsp_id;
    assign rsp_sum    = r_sum;
    assign rsp_cout   = r_cout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_acc        <= '0;
            r_sum        <= '0;
            r_idx        <= '0;
            r_carry      <= 1'b0;
            r_cout       <= 1'b0;
            r_id         <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_a          <= w_gnt1 ? req1_a : req0_a;
                        r_b          <= w_gnt1 ? req1_b : req0_b;
                        r_id         <= w_gnt1;
                        r_last_grant <= w_gnt1;
                        r_idx        <= '0;
                        r_carry      <= 1'b0;
                        r_acc        <= '0;
                        r_state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_carry_next;
                    r_idx   <= r_idx + 1'b1;
                    // Result registers only update at completion so the last response stays visible.
                    if (r_idx == IDXW'(NCHUNK - 1)) begin
                        r_sum    <= w_acc_next;
                        r_cout   <= w_carry_next;
                        r_rsp_id <= r_id;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_chunk_scheduler.sv
// Self-checking bench: directed vector table, arbitration/backpressure/reset
// sequences, then randomized traffic against a queue-based reference model.
module tb_adder_chunk_scheduler;

    localparam int W  = 32;
    localparam int NC = W / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
    logic [W-1:0]  rsp_sum;
    logic [7:0]    dp_a, dp_b, dp_s;

    int checks   = 0;
    int failures = 0;

    adder_chunk_scheduler #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .dp_a(dp_a), .dp_b(dp_b), .dp_s(dp_s), .busy(busy)
    );

    // External 8-bit adder: no carry in, no carry out.
    assign dp_s = dp_a + dp_b;

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int gid);
        gid = -1;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (req0_valid && req0_ready) gid = 0;
            else if (req1_valid && req1_ready) gid = 1;
            tick();
            if (gid >= 0) break;
        end
        if (gid < 0) begin
            checks++;
            failures++;
            $display("FAIL grant_timeout actual=none expected=grant");
        end
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (!busy) break;
            tick();
        end
        chk("drain_idle", busy, 1'b0);
    endtask

    typedef struct {
        logic         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v);
        logic [7:0] ea, eb;
        rsp_ready  = 1'b1;
        req0_valid = (v.id == 1'b0);
        req1_valid = (v.id == 1'b1);
        req0_a = v.a; req0_b = v.b;
        req1_a = v.a; req1_b = v.b;
        #1;
        chk("vec_ready", v.id ? req1_ready : req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int k = 0; k < NC; k++) begin
            ea = 8'(v.a >> (8 * k));
            eb = 8'(v.b >> (8 * k));
            chk("vec_dp_a", dp_a, ea);
            chk("vec_dp_b", dp_b, eb);
            chk("vec_rsp_valid_early", rsp_valid, 1'b0);
            tick();
        end
        chk("vec_rsp_valid", rsp_valid, 1'b1);
        chk("vec_sum", rsp_sum, v.sum);
        chk("vec_cout", rsp_cout, v.cout);
        chk("vec_id", rsp_id, v.id);
        tick();
        chk("vec_rsp_drop", rsp_valid, 1'b0);
        chk("vec_idle", busy, 1'b0);
    endtask

    typedef struct {
        logic       id;
        logic [W:0] full;
    } exp_t;

    initial begin
        int     g;
        int     exp_g[6];
        exp_t   q[$];
        exp_t   e;
        int     m_phase, m_cnt, ops_done, cyc;
        logic   m_last, g0, g1, pend0, pend1;
        logic [W-1:0] a0, b0, a1, b1;

        vecs[0] = '{1'b0, 32'h12345678, 32'h0F0F0F0F, 32'h21436587, 1'b0};
        vecs[1] = '{1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
        vecs[2] = '{1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0};
        vecs[3] = '{1'b1, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1};
        vecs[4] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0};
        vecs[5] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1};

        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        tick();
        tick();
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_id", rsp_id, 1'b0);
        chk("rst_rsp_sum", rsp_sum, '0);
        chk("rst_rsp_cout", rsp_cout, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_dp_a", dp_a, 8'h00);
        chk("rst_dp_b", dp_b, 8'h00);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Arbitration: both valid after reset alternate 0,1,0,1; then req1 alone twice.
        rst = 1'b1; tick(); rst = 1'b0;
        exp_g = '{0, 1, 0, 1, 1, 1};
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) req0_valid = 1'b0;
            wait_grant(g);
            chk("arb_grant", g, exp_g[i]);
            req0_a = $urandom; req1_a = $urandom;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();

        // Backpressure: hold the response for 10 cycles with both requesters waiting.
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'hF0000001; req0_b = 32'h20000002;
        wait_grant(g);
        chk("bp_grant", g, 0);
        req0_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (rsp_valid) break;
            tick();
        end
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2;
        req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("bp_rsp_valid", rsp_valid, 1'b1);
            chk("bp_sum", rsp_sum, 32'h10000003);
            chk("bp_cout", rsp_cout, 1'b1);
            chk("bp_id", rsp_id, 1'b0);
            chk("bp_ready0", req0_ready, 1'b0);
            chk("bp_ready1", req1_ready, 1'b0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        #1;
        chk("bp_rel_valid", rsp_valid, 1'b0);
        chk("bp_rel_busy", busy, 1'b0);
        chk("bp_keep_sum", rsp_sum, 32'h10000003);
        chk("bp_next_ready1", req1_ready, 1'b1);
        chk("bp_next_ready0", req0_ready, 1'b0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("bp_next_accepted", busy, 1'b1);
        drain();

        // Reset at idx=2 of a req0 operation.
        req0_valid = 1'b1; req0_a = 32'hAABBCCDD; req0_b = 32'h11223344;
        wait_grant(g);
        chk("mr_grant", g, 0);
        req0_valid = 1'b0;
        tick();
        tick();
        chk("mr_idx2_dp_a", dp_a, 8'hBB);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_busy", busy, 1'b0);
        chk("mr_rsp_valid", rsp_valid, 1'b0);
        chk("mr_dp_a", dp_a, 8'h00);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("mr_ready0", req0_ready, 1'b1);
        chk("mr_ready1", req1_ready, 1'b0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("mr_no_rsp", rsp_valid, 1'b0);
        end

        // Randomized traffic against a transaction-level model.
        rst = 1'b1; tick(); rst = 1'b0;
        m_phase = 0; m_cnt = 0; m_last = 1'b1; ops_done = 0;
        pend0 = 1'b0; pend1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        for (cyc = 0; cyc < 40000 && ops_done < 1000; cyc++) begin
            if (!pend0 && $urandom_range(0, 2) != 0) begin
                pend0 = 1'b1;
                a0 = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
                b0 = W'($urandom);
            end
            if (!pend1 && $urandom_range(0, 2) != 0) begin
                pend1 = 1'b1;
                a1 = W'($urandom);
                b1 = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
            end
            req0_valid = pend0; req0_a = a0; req0_b = b0;
            req1_valid = pend1; req1_a = a1; req1_b = b1;
            rsp_ready  = 1'($urandom_range(0, 1));
            #1;
            g0 = (m_phase == 0) && pend0 && (!pend1 || m_last);
            g1 = (m_phase == 0) && pend1 && (!pend0 || !m_last);
            chk("rnd_ready0", req0_ready, g0);
            chk("rnd_ready1", req1_ready, g1);
            chk("rnd_rsp_valid", rsp_valid, m_phase == 2);
            chk("rnd_busy", busy, m_phase != 0);
            if (m_phase == 2 && q.size() > 0) begin
                e = q[0];
                chk("rnd_sum", rsp_sum, e.full[W-1:0]);
                chk("rnd_cout", rsp_cout, e.full[W]);
                chk("rnd_id", rsp_id, e.id);
            end
            if (g0 || g1) begin
                e.id   = g1;
                e.full = g1 ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
                q.push_back(e);
                m_last  = g1;
                if (g1) pend1 = 1'b0; else pend0 = 1'b0;
                m_phase = 1;
                m_cnt   = NC;
            end else if (m_phase == 1) begin
                m_cnt--;
                if (m_cnt == 0) m_phase = 2;
            end else if (m_phase == 2 && rsp_ready) begin
                void'(q.pop_front());
                ops_done++;
                m_phase = 0;
            end
            tick();
        end
        chk("rnd_ops_done", ops_done, 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder_chunk_scheduler.md
Name: adder_chunk_scheduler

Overview:
- Shares one 8-bit prefix adder datapath between two requesters.
- Sequences each WIDTH-bit addition over WIDTH/8 cycles. The controller drives one byte slice per cycle into the external 8-bit adder.
- The adder has no carry-in and no carry-out, so the controller applies the inter-chunk carry itself and derives each chunk's carry-out.
- Arbitration between requesters is round-robin. Each accepted operation returns one response carrying the requester ID.

Parameters:
- WIDTH, 32, operand width in bits. Must be a multiple of 8 and ≥ 8. NCHUNK = WIDTH/8 is derived.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle (when valid)
- req0_a  in  WIDTH  requester 0 operand A
- req0_b  in  WIDTH  requester 0 operand B
- req1_valid  in  1  requester 1 has an operation
- req1_ready  out  1  requester 1 operation accepted this cycle (when valid)
- req1_a  in  WIDTH  requester 1 operand A
- req1_b  in  WIDTH  requester 1 operand B
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester that issued the result
- rsp_sum  out  WIDTH  (A+B) mod 2^WIDTH
- rsp_cout  out  1  carry out of bit WIDTH-1
- dp_a  out  8  byte slice of A to the external adder
- dp_b  out  8  byte slice of B to the external adder
- dp_s  in  8  external adder sum, combinational from dp_a/dp_b
- busy  out  1  high in RUN and DONE

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset (rst=1 at an edge): state=IDLE, chunk index=0, carry=0, result register=0, last_grant=1 (requester 0 wins first).
  - Outputs after reset: rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, busy=0, dp_a=dp_b=0.
  - Reset in RUN or DONE aborts the operation silently; no response is produced.
- IDLE:
  - Grant is combinational. With exactly one reqN_valid, that requester gets reqN_ready=1.
  - With both valid, the requester not equal to last_grant gets ready.
  - At most one ready is high at a time. Both ready signals are 0 outside IDLE.
  - On handshake: capture A, B, id; set idx=0, carry=0; last_grant=id; go to RUN.
  - With no valid: stay in IDLE.
- RUN (one chunk per cycle):
  - dp_a = A[8*idx+7 : 8*idx], dp_b = B[8*idx+7 : 8*idx]. dp_a/dp_b are 0 outside RUN.
  - Chunk sum: t = {1'b0, dp_s} + carry (9 bits). Result byte idx = t[7:0].
  - Next carry = (a7 & b7) | ((a7 ^ b7) & ~dp_s[7]) | t[8], where a7/b7 are bit 7 of the current A/B slices. At most one of the dp carry term and t[8] can be 1.
  - idx increments each cycle. After the cycle with idx = NCHUNK-1: rsp_cout = final carry, go to DONE.
- DONE:
  - rsp_valid=1. rsp_sum, rsp_cout and rsp_id are held stable until rsp_ready=1.
  - On handshake: go to IDLE.
  - rsp_valid falls the cycle after the handshake; rsp_sum, rsp_cout and rsp_id keep their last values.
- Latency and throughput:
  - Request accepted at edge T → rsp_valid high from edge T+NCHUNK onward.
  - Earliest next acceptance is the cycle after the response handshake.
  - Sustained throughput is one operation per NCHUNK+2 cycles with rsp_ready held high.
- Requests arriving while busy wait (ready=0). Requesters must hold valid and operands stable until accepted.
- Wrap-around: the sum is modulo 2^WIDTH; overflow is reported only via rsp_cout.

Test Plan:
- WIDTH=32, req0 0x12345678 + 0x0F0F0F0F, rsp_ready=1 → rsp_sum=0x21436587, cout=0, id=0, rsp_valid first high 4 cycles after accept; dp_a sequence 0x78, 0x56, 0x34, 0x12.
- Carry chain: req1 0xFFFFFFFF + 0x00000001 → sum=0x00000000, cout=1, id=1; also 0x000000FF + 0x00000001 → 0x00000100, cout=0.
- Arbitration: both valid continuously after reset → grants 0,1,0,1; when only req1 is valid twice, req1 is granted both times.
- Backpressure: rsp_ready=0 for 10 cycles in DONE → rsp_valid stays 1, sum/cout/id stable, both ready=0; release → IDLE next cycle, next request accepted.
- Reset mid-RUN (idx=2) → next cycle: IDLE, busy=0, rsp_valid=0, dp_a=0; the aborted operation never responds; the next grant goes to req0 when both are valid.
- Random: 1000 operations, random valids/rsp_ready, results checked against a WIDTH+1-bit reference sum.
